// File: rtl/agc_rt_sequencer_pkg.sv
// Shared types for the A/L/Q/Z/B/G/X/Y register-transfer sequencer: opcodes,
// timepulse numbers, gate-vector bit positions and the per-op gate decode table.
package agc_rt_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CA   = 3'd1,
    OP_CS   = 3'd2,
    OP_AD   = 3'd3,
    OP_TS   = 3'd4,
    OP_XCH  = 3'd5,
    OP_INCR = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  typedef enum logic [3:0] {
    TP01 = 4'd1, TP02 = 4'd2, TP03 = 4'd3, TP04 = 4'd4,
    TP05 = 4'd5, TP06 = 4'd6, TP07 = 4'd7, TP08 = 4'd8,
    TP09 = 4'd9, TP10 = 4'd10, TP11 = 4'd11, TP12 = 4'd12
  } tp_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } seq_state_e;

  // Gate vector is active-high internally; the slice-facing strobes are inverted at the ports.
  localparam int GV_W     = 11;
  localparam int GI_RAG   = 0;
  localparam int GI_RBLG  = 1;
  localparam int GI_RCG   = 2;
  localparam int GI_RGG   = 3;
  localparam int GI_RULOG = 4;
  localparam int GI_WAG   = 5;
  localparam int GI_WBG   = 6;
  localparam int GI_WG1G  = 7;
  localparam int GI_WYDG  = 8;
  localparam int GI_A2XG  = 9;
  localparam int GI_PONEX = 10;

  typedef logic [GV_W-1:0] gate_vec_t;

  // Read-side gates (incl. A2X and PONEX) span the whole timepulse; write gates only the write phase.
  function automatic gate_vec_t gate_decode(op_e op, logic [3:0] tp, logic wr_ph);
    gate_vec_t rd;
    gate_vec_t wr;
    rd = '0;
    wr = '0;
    case (op)
      OP_CA, OP_CS, OP_AD, OP_XCH: begin
        if (tp == TP05) begin rd[GI_RGG] = 1'b1; wr[GI_WBG] = 1'b1; end
        if (op == OP_CA && tp == TP07) begin rd[GI_RBLG] = 1'b1; wr[GI_WAG] = 1'b1; end
        if (op == OP_CS && tp == TP07) begin rd[GI_RCG] = 1'b1; wr[GI_WAG] = 1'b1; end
        if (op == OP_AD && tp == TP06) begin
          rd[GI_A2XG] = 1'b1; rd[GI_RBLG] = 1'b1; wr[GI_WYDG] = 1'b1;
        end
        if (op == OP_AD && tp == TP07) begin rd[GI_RULOG] = 1'b1; wr[GI_WAG] = 1'b1; end
        if (op == OP_XCH && tp == TP06) begin rd[GI_RAG] = 1'b1; wr[GI_WG1G] = 1'b1; end
        if (op == OP_XCH && tp == TP07) begin rd[GI_RBLG] = 1'b1; wr[GI_WAG] = 1'b1; end
      end
      OP_TS: begin
        if (tp == TP05) begin rd[GI_RAG] = 1'b1; wr[GI_WG1G] = 1'b1; end
      end
      OP_INCR: begin
        if (tp == TP05) begin rd[GI_RGG] = 1'b1; rd[GI_PONEX] = 1'b1; wr[GI_WYDG] = 1'b1; end
        if (tp == TP06) begin rd[GI_RULOG] = 1'b1; wr[GI_WG1G] = 1'b1; end
      end
      default: ;
    endcase
    return rd | (wr_ph ? wr : '0);
  endfunction

endpackage

// File: rtl/agc_rt_sequencer_if.sv
// Operation request handshake, timing status and slice gate strobes of the sequencer.
interface agc_rt_sequencer_if;
  import agc_rt_sequencer_pkg::*;

  // Handshake: OPREQ is a level "valid" held with a stable OPCODE until OPACK.
  // The sequencer is "ready" only on the edge that ends TPEND; OPACK then pulses
  // for exactly one clock. A request still high after OPACK is a new request.
  logic       STRT2;
  logic       OPREQ;
  logic [2:0] OPCODE;
  logic       OPACK;
  logic       BUSY;
  logic       OPERR;
  logic [3:0] TPNUM;
  logic       TPEND;
  logic       RAG_, RBLG_, RCG_, RGG_, RULOG_;
  logic       WAG_, WBG_, WG1G_, WYDG_;
  logic       A2XG_;
  logic       PONEX;
  logic [3:0] DBG_PHASE;
  seq_state_e DBG_STATE;

  modport master (
    output STRT2, OPREQ, OPCODE,
    input  OPACK, BUSY, OPERR, TPNUM, TPEND,
    input  RAG_, RBLG_, RCG_, RGG_, RULOG_, WAG_, WBG_, WG1G_, WYDG_, A2XG_, PONEX,
    input  DBG_PHASE, DBG_STATE
  );

  modport slave (
    input  STRT2, OPREQ, OPCODE,
    output OPACK, BUSY, OPERR, TPNUM, TPEND,
    output RAG_, RBLG_, RCG_, RGG_, RULOG_, WAG_, WBG_, WG1G_, WYDG_, A2XG_, PONEX,
    output DBG_PHASE, DBG_STATE
  );

endinterface

// File: rtl/agc_rt_sequencer_tp_counter.sv
// Free-running phase/timepulse counter (T01..T12) with STRT2 hold at T01/phase 0.
module agc_tp_counter
  import agc_rt_sequencer_pkg::*;
#(
  parameter int PHASES = 2,
  parameter int PW     = $clog2(PHASES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          strt2_i,
  output logic [3:0]    tp_o,
  output logic [PW-1:0] ph_o,
  output logic          tpend_o,
  output logic [3:0]    tp_nxt_o,
  output logic [PW-1:0] ph_nxt_o
);

  localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

  logic [3:0]    tp_q, tp_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          tpend_q, tpend_d;

  always_comb begin
    tp_d = tp_q;
    ph_d = ph_q;
    if (strt2_i) begin
      tp_d = TP01;
      ph_d = '0;
    end else if (ph_q == PH_LAST) begin
      ph_d = '0;
      tp_d = (tp_q == TP12) ? TP01 : tp_q + 4'd1;
    end else begin
      ph_d = ph_q + PW'(1);
    end
    tpend_d = (tp_d == TP12) && (ph_d == PH_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tp_q    <= TP01;
      ph_q    <= '0;
      tpend_q <= 1'b0;
    end else begin
      tp_q    <= tp_d;
      ph_q    <= ph_d;
      tpend_q <= tpend_d;
    end
  end

  assign tp_o     = tp_q;
  assign ph_o     = ph_q;
  assign tpend_o  = tpend_q;
  assign tp_nxt_o = tp_d;
  assign ph_nxt_o = ph_d;

endmodule

// File: rtl/agc_rt_sequencer.sv
// Register-transfer sequencer: latches one op per memory cycle at TPEND and drives
// registered active-low slice gates from the op table for the following cycle.
module agc_rt_sequencer
  import agc_rt_sequencer_pkg::*;
#(
  parameter int PHASES = 2
) (
  input logic                CLOCK,
  input logic                rst,
  agc_rt_sequencer_if.slave  bus
);

  localparam int            PW      = $clog2(PHASES);
  localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

  logic [3:0]    tp, tp_nxt;
  logic [PW-1:0] ph, ph_nxt;
  logic          tpend;

  agc_tp_counter #(.PHASES(PHASES), .PW(PW)) u_tp_counter (
    .clk_i    (CLOCK),
    .rst_i    (rst),
    .strt2_i  (bus.STRT2),
    .tp_o     (tp),
    .ph_o     (ph),
    .tpend_o  (tpend),
    .tp_nxt_o (tp_nxt),
    .ph_nxt_o (ph_nxt)
  );

  op_e        op_q, op_d;
  logic       ack_q, ack_d;
  logic       operr_q, operr_d;
  logic       busy_q;
  seq_state_e state_q, state_d;
  gate_vec_t  gates_q, gates_d;

  // Code 7 is acknowledged and flagged but runs as a NOP, so BUSY stays low for it.
  always_comb begin
    op_d    = op_q;
    ack_d   = 1'b0;
    operr_d = operr_q;
    if (bus.STRT2) begin
      op_d = OP_NOP;
    end else if (tpend) begin
      ack_d = bus.OPREQ;
      op_d  = OP_NOP;
      if (bus.OPREQ) begin
        if (op_e'(bus.OPCODE) == OP_RSV) operr_d = 1'b1;
        else                             op_d    = op_e'(bus.OPCODE);
      end
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (bus.STRT2)            state_d = S_HOLD;
    else if (op_d != OP_NOP)  state_d = S_EXEC;
    gates_d = (state_d == S_HOLD) ? '0 : gate_decode(op_d, tp_nxt, ph_nxt == PH_LAST);
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      op_q    <= OP_NOP;
      ack_q   <= 1'b0;
      operr_q <= 1'b0;
      busy_q  <= 1'b0;
      gates_q <= '0;
    end else begin
      op_q    <= op_d;
      ack_q   <= ack_d;
      operr_q <= operr_d;
      busy_q  <= (state_d == S_EXEC);
      gates_q <= gates_d;
    end
  end

  assign bus.OPACK     = ack_q;
  assign bus.BUSY      = busy_q;
  assign bus.OPERR     = operr_q;
  assign bus.TPNUM     = tp;
  assign bus.TPEND     = tpend;
  assign bus.RAG_      = ~gates_q[GI_RAG];
  assign bus.RBLG_     = ~gates_q[GI_RBLG];
  assign bus.RCG_      = ~gates_q[GI_RCG];
  assign bus.RGG_      = ~gates_q[GI_RGG];
  assign bus.RULOG_    = ~gates_q[GI_RULOG];
  assign bus.WAG_      = ~gates_q[GI_WAG];
  assign bus.WBG_      = ~gates_q[GI_WBG];
  assign bus.WG1G_     = ~gates_q[GI_WG1G];
  assign bus.WYDG_     = ~gates_q[GI_WYDG];
  assign bus.A2XG_     = ~gates_q[GI_A2XG];
  assign bus.PONEX     = gates_q[GI_PONEX];
  assign bus.DBG_PHASE = 4'(ph);
  assign bus.DBG_STATE = state_q;

endmodule
